image_frame_buffer: RTL and testbench

IMAGE_FRAME_BUFFER -- requirements
Module: image_frame_buffer

---
 rtl/image_frame_buffer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_image_frame_buffer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_frame_buffer.sv
// Image frame buffer: a ring of frame slots between an image pipe sink and source.
// Independent receive and send FSMs share the ring; optional registered pixel read port.
`ifndef IS_DEFAULT
`define IS_DEFAULT {16'd64, 16'd48, 8'd8}
`endif
`ifndef IS_WIDTH
`define IS_WIDTH(s) int'((s) >> 24)
`endif
`ifndef IS_HEIGHT
`define IS_HEIGHT(s) int'(((s) >> 8) & 40'hFFFF)
`endif
`ifndef IS_DATA_WIDTH
`define IS_DATA_WIDTH(s) int'((s) & 40'hFF)
`endif
`ifndef IS_WIDTH_WIDTH
`define IS_WIDTH_WIDTH(s) ((`IS_WIDTH(s) > 1) ? $clog2(`IS_WIDTH(s)) : 1)
`endif
`ifndef IS_HEIGHT_WIDTH
`define IS_HEIGHT_WIDTH(s) ((`IS_HEIGHT(s) > 1) ? $clog2(`IS_HEIGHT(s)) : 1)
`endif
`ifndef I_w
`define I_w(s) (`IS_DATA_WIDTH(s) + 7)
`endif

module image_frame_buffer #(
    parameter logic [39:0] IS = `IS_DEFAULT,
    parameter int FrameCount = 2,
    parameter bit ImplementAccessPort = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic in_request_external,
    input  logic out_request_external,
    inout  wire  [`I_w(IS)-1:0] image_in,
    inout  wire  [`I_w(IS)-1:0] image_out,
    output logic in_receiving,
    output logic out_sending,
    output logic [$clog2(FrameCount+1)-1:0] frames_stored,
    output logic frame_dropped,
    input  logic [`IS_WIDTH_WIDTH(IS)-1:0] buffer_out_x,
    input  logic [`IS_HEIGHT_WIDTH(IS)-1:0] buffer_out_y,
    output logic [`IS_DATA_WIDTH(IS)-1:0] buffer_out_data
);

    localparam int W = `IS_WIDTH(IS);
    localparam int H = `IS_HEIGHT(IS);
    localparam int DW = `IS_DATA_WIDTH(IS);
    localparam int PC = W * H;
    localparam int DEPTH = FrameCount * PC;
    localparam int IW = (PC > 1) ? $clog2(PC) : 1;
    localparam int FW = $clog2(FrameCount);
    localparam int SW = $clog2(FrameCount + 1);
    localparam int AW = $clog2(DEPTH);

    // Pipe bit layout: data, then start/stop/valid/error forward, request/cancel/ready back
    localparam int B_START = DW;
    localparam int B_STOP = DW + 1;
    localparam int B_VALID = DW + 2;
    localparam int B_ERROR = DW + 3;
    localparam int B_REQUEST = DW + 4;
    localparam int B_CANCEL = DW + 5;
    localparam int B_READY = DW + 6;

    typedef enum logic {RX_IDLE, RX_RECEIVING} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SENDING} tx_state_t;

    rx_state_t rx_state;
    tx_state_t tx_state;

    logic [DW-1:0] mem [DEPTH] = '{default: '0};

    logic [IW-1:0] rx_index;
    logic [IW-1:0] tx_index;
    logic [FW-1:0] wr_frame;
    logic [FW-1:0] rd_frame;
    logic [FW-1:0] last_frame;

    logic in_request;
    logic in_ready;
    logic out_start;
    logic out_stop;
    logic out_valid;
    logic [DW-1:0] out_data;

    logic [DW-1:0] in_data_i;
    logic in_start_i;
    logic in_valid_i;
    logic in_error_i;
    logic out_request_i;
    logic out_cancel_i;
    logic out_ready_i;

    assign in_data_i = image_in[DW-1:0];
    assign in_start_i = image_in[B_START];
    assign in_valid_i = image_in[B_VALID];
    assign in_error_i = image_in[B_ERROR];
    assign image_in[B_REQUEST] = in_request;
    assign image_in[B_CANCEL] = 1'b0;
    assign image_in[B_READY] = in_ready;

    assign image_out[DW-1:0] = out_data;
    assign image_out[B_START] = out_start;
    assign image_out[B_STOP] = out_stop;
    assign image_out[B_VALID] = out_valid;
    assign image_out[B_ERROR] = 1'b0;
    assign out_request_i = image_out[B_REQUEST];
    assign out_cancel_i = image_out[B_CANCEL];
    assign out_ready_i = image_out[B_READY];

    logic unused_pipe;
    assign unused_pipe = image_in[B_STOP];

    assign in_receiving = (rx_state != RX_IDLE);
    assign out_sending = (tx_state != TX_IDLE);

    logic [IW-1:0] rx_idx;
    logic [IW-1:0] tx_fetch;
    logic rx_accept;
    logic rx_last;
    logic tx_last;
    logic commit;
    logic rel_frame;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    function automatic logic [FW-1:0] next_slot(input logic [FW-1:0] f);
        return (f == FW'(FrameCount - 1)) ? '0 : f + 1'b1;
    endfunction

    always_comb begin
        rx_idx = in_start_i ? '0 : rx_index;
        rx_accept = (rx_state == RX_RECEIVING) && !in_error_i && in_valid_i
                    && ((rx_index != '0) || in_start_i);
        rx_last = (rx_idx == IW'(PC - 1));
        commit = rx_accept && rx_last;
        tx_last = (tx_index == IW'(PC - 1));
        rel_frame = (tx_state == TX_SENDING) && !out_cancel_i && out_ready_i && tx_last;
        tx_fetch = '0;
        if (tx_state == TX_SENDING && !tx_last) begin
            tx_fetch = tx_index + 1'b1;
        end
        wr_addr = AW'(wr_frame) * AW'(PC) + AW'(rx_idx);
        rd_addr = AW'(rd_frame) * AW'(PC) + AW'(tx_fetch);
    end

    assign rd_data = mem[rd_addr];

    always_ff @(posedge clock) begin
        if (rx_accept) begin
            mem[wr_addr] <= in_data_i;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            tx_state <= TX_IDLE;
            rx_index <= '0;
            tx_index <= '0;
            wr_frame <= '0;
            rd_frame <= '0;
            last_frame <= '0;
            frames_stored <= '0;
            in_request <= 1'b0;
            in_ready <= 1'b0;
            out_start <= 1'b0;
            out_stop <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
            frame_dropped <= 1'b0;
        end else begin
            frame_dropped <= 1'b0;

            case (rx_state)
                RX_IDLE: begin
                    if (in_request_external && frames_stored < SW'(FrameCount)) begin
                        rx_state <= RX_RECEIVING;
                        in_request <= 1'b1;
                        in_ready <= 1'b1;
                    end
                end
                RX_RECEIVING: begin
                    if (in_error_i) begin
                        rx_state <= RX_IDLE;
                        rx_index <= '0;
                        in_request <= 1'b0;
                        in_ready <= 1'b0;
                        frame_dropped <= (rx_index != '0);
                    end else if (rx_accept) begin
                        in_request <= 1'b0;
                        // A start mid-frame throws away what was collected so far
                        if (in_start_i && rx_index != '0) begin
                            frame_dropped <= 1'b1;
                        end
                        if (rx_last) begin
                            wr_frame <= next_slot(wr_frame);
                            last_frame <= wr_frame;
                            rx_index <= '0;
                            in_ready <= 1'b0;
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_index <= rx_idx + 1'b1;
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase

            case (tx_state)
                TX_IDLE: begin
                    if ((out_request_i || out_request_external) && frames_stored != '0) begin
                        tx_state <= TX_SENDING;
                        tx_index <= '0;
                        out_start <= 1'b1;
                        out_valid <= 1'b1;
                        out_stop <= (PC == 1);
                        out_data <= rd_data;
                    end
                end
                TX_SENDING: begin
                    // Cancel keeps the frame stored so the next request resends it
                    if (out_cancel_i || rel_frame) begin
                        tx_state <= TX_IDLE;
                        tx_index <= '0;
                        out_start <= 1'b0;
                        out_stop <= 1'b0;
                        out_valid <= 1'b0;
                        out_data <= '0;
                        if (rel_frame) begin
                            rd_frame <= next_slot(rd_frame);
                        end
                    end else if (out_ready_i) begin
                        tx_index <= tx_fetch;
                        out_start <= 1'b0;
                        out_stop <= (tx_fetch == IW'(PC - 1));
                        out_data <= rd_data;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase

            case ({commit, rel_frame})
                2'b10: frames_stored <= frames_stored + 1'b1;
                2'b01: frames_stored <= frames_stored - 1'b1;
                default: frames_stored <= frames_stored;
            endcase
        end
    end

    generate
        if (ImplementAccessPort) begin : g_access
            logic [AW-1:0] ap_addr;
            assign ap_addr = AW'(last_frame) * AW'(PC)
                             + AW'(buffer_out_y) * AW'(W) + AW'(buffer_out_x);
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    buffer_out_data <= '0;
                end else begin
                    buffer_out_data <= mem[ap_addr];
                end
            end
        end else begin : g_no_access
            logic unused_access;
            assign unused_access = ^{buffer_out_x, buffer_out_y, last_frame};
            assign buffer_out_data = '0;
        end
    endgenerate

endmodule

// File: tb/tb_image_frame_buffer.sv
// Directed bench for image_frame_buffer with 4x2 frames of 8-bit pixels.
// Output pixels are queued as frames are fed in and popped as they leave.
module tb_image_frame_buffer;

    localparam logic [39:0] IS = {16'd4, 16'd2, 8'd8};
    localparam int PC = 8;

    typedef struct packed {
        logic [7:0] d;
        logic s;
        logic e;
    } pix_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic in_request_external = 1'b0;
    logic out_request_external = 1'b0;
    wire [14:0] image_in;
    wire [14:0] image_out;
    logic in_receiving;
    logic out_sending;
    logic [1:0] frames_stored;
    logic frame_dropped;
    logic [1:0] buffer_out_x = '0;
    logic [0:0] buffer_out_y = '0;
    logic [7:0] buffer_out_data;

    logic [7:0] in_data = '0;
    logic in_start = 1'b0;
    logic in_stop = 1'b0;
    logic in_valid = 1'b0;
    logic in_error = 1'b0;
    logic out_request = 1'b0;
    logic out_cancel = 1'b0;
    logic out_ready = 1'b0;

    assign image_in[11:0] = {in_error, in_valid, in_stop, in_start, in_data};
    assign image_out[14:12] = {out_ready, out_cancel, out_request};

    wire i_request = image_in[12];
    wire i_ready = image_in[14];
    wire [7:0] o_data = image_out[7:0];
    wire o_start = image_out[8];
    wire o_stop = image_out[9];
    wire o_valid = image_out[10];

    int vectors = 0;
    int miscompares = 0;
    pix_t q[$];

    image_frame_buffer #(
        .IS(IS),
        .FrameCount(2),
        .ImplementAccessPort(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_request_external(in_request_external),
        .out_request_external(out_request_external),
        .image_in(image_in),
        .image_out(image_out),
        .in_receiving(in_receiving),
        .out_sending(out_sending),
        .frames_stored(frames_stored),
        .frame_dropped(frame_dropped),
        .buffer_out_x(buffer_out_x),
        .buffer_out_y(buffer_out_y),
        .buffer_out_data(buffer_out_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_pix(input int v, input bit s, input bit e);
        in_data = 8'(v);
        in_start = s;
        in_stop = e;
        in_valid = 1'b1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_start = 1'b0;
        in_stop = 1'b0;
        in_data = '0;
    endtask

    task automatic recv_frame(input int base, input int bound);
        int n;
        in_request_external = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!i_ready && n < bound);
        chk("rx_armed", 32'(i_ready), 1);
        in_request_external = 1'b0;
        for (int k = 0; k < PC; k++) begin
            drive_pix(base + k, k == 0, k == PC - 1);
            q.push_back(pix_t'{d: 8'(base + k), s: (k == 0), e: (k == PC - 1)});
            @(negedge clock);
        end
        idle_in();
    endtask

    task automatic send_frame();
        int n;
        pix_t p;
        out_request_external = 1'b1;
        out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!o_valid && n < 4);
        chk("tx_started", 32'(o_valid), 1);
        out_request_external = 1'b0;
        for (int k = 0; k < PC; k++) begin
            p = (q.size() > 0) ? q.pop_front() : '0;
            chk("tx_data", 32'(o_data), 32'(p.d));
            chk("tx_start", 32'(o_start), 32'(p.s));
            chk("tx_stop", 32'(o_stop), 32'(p.e));
            @(negedge clock);
        end
        chk("tx_done", 32'(o_valid), 0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_receiving", 32'(in_receiving), 0);
        chk("rst_sending", 32'(out_sending), 0);
        chk("rst_stored", 32'(frames_stored), 0);
        chk("rst_dropped", 32'(frame_dropped), 0);
        chk("rst_in_ready", 32'(i_ready), 0);
        chk("rst_in_request", 32'(i_request), 0);
        chk("rst_out_valid", 32'(o_valid), 0);
        chk("rst_out_data", 32'(o_data), 0);
        chk("rst_access", 32'(buffer_out_data), 0);
        reset = 1'b1;
        @(negedge clock);

        // single frame round trip and access port
        recv_frame(1, 3);
        chk("one_stored", 32'(frames_stored), 1);
        buffer_out_x = 2'd3;
        buffer_out_y = 1'b1;
        @(negedge clock);
        chk("access_x3y1", 32'(buffer_out_data), 8);
        buffer_out_x = 2'd0;
        buffer_out_y = 1'b0;
        @(negedge clock);
        chk("access_x0y0", 32'(buffer_out_data), 1);
        send_frame();
        chk("one_sent", 32'(frames_stored), 0);

        // full ring blocks reception until a slot is released
        recv_frame(1, 3);
        recv_frame(11, 3);
        chk("two_stored", 32'(frames_stored), 2);
        in_request_external = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("full_ready", 32'(i_ready), 0);
            chk("full_receiving", 32'(in_receiving), 0);
        end
        send_frame();
        recv_frame(31, 2);
        chk("refill_stored", 32'(frames_stored), 2);
        send_frame();
        send_frame();
        chk("drained", 32'(frames_stored), 0);

        // error aborts a partial frame
        in_request_external = 1'b1;
        @(negedge clock);
        chk("err_armed", 32'(i_ready), 1);
        in_request_external = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_pix(21 + k, k == 0, 1'b0);
            @(negedge clock);
        end
        idle_in();
        in_error = 1'b1;
        @(negedge clock);
        chk("err_dropped", 32'(frame_dropped), 1);
        chk("err_stored", 32'(frames_stored), 0);
        chk("err_receiving", 32'(in_receiving), 0);
        chk("err_ready", 32'(i_ready), 0);
        in_error = 1'b0;
        @(negedge clock);
        chk("err_pulse_end", 32'(frame_dropped), 0);
        recv_frame(21, 3);
        send_frame();

        // start mid-frame restarts reception
        in_request_external = 1'b1;
        @(negedge clock);
        chk("rs_armed", 32'(i_ready), 1);
        in_request_external = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_pix(41 + k, k == 0, 1'b0);
            @(negedge clock);
        end
        for (int k = 0; k < PC; k++) begin
            drive_pix(51 + k, k == 0, k == PC - 1);
            q.push_back(pix_t'{d: 8'(51 + k), s: (k == 0), e: (k == PC - 1)});
            @(negedge clock);
            if (k == 0) chk("rs_dropped", 32'(frame_dropped), 1);
        end
        idle_in();
        chk("rs_stored", 32'(frames_stored), 1);
        send_frame();

        // cancel mid-send keeps the frame for a full resend
        recv_frame(61, 3);
        out_request_external = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        chk("cx_valid", 32'(o_valid), 1);
        out_request_external = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("cx_data", 32'(o_data), 32'(q[k].d));
            @(negedge clock);
        end
        chk("cx_pix5", 32'(o_data), 65);
        out_cancel = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        chk("cx_out_valid", 32'(o_valid), 0);
        chk("cx_out_data", 32'(o_data), 0);
        chk("cx_out_start", 32'(o_start), 0);
        chk("cx_sending", 32'(out_sending), 0);
        chk("cx_stored", 32'(frames_stored), 1);
        out_cancel = 1'b0;
        send_frame();
        chk("cx_released", 32'(frames_stored), 0);

        // last pixel in and last pixel out on the same edge
        recv_frame(71, 3);
        in_request_external = 1'b1;
        out_request_external = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        chk("ov_in_ready", 32'(i_ready), 1);
        chk("ov_out_valid", 32'(o_valid), 1);
        in_request_external = 1'b0;
        out_request_external = 1'b0;
        for (int k = 0; k < PC; k++) begin
            drive_pix(81 + k, k == 0, k == PC - 1);
            chk("ov_data", 32'(o_data), 32'(q[k].d));
            @(negedge clock);
        end
        idle_in();
        chk("ov_stored", 32'(frames_stored), 1);
        chk("ov_out_idle", 32'(o_valid), 0);
        repeat (PC) void'(q.pop_front());
        for (int k = 0; k < PC; k++) begin
            q.push_back(pix_t'{d: 8'(81 + k), s: (k == 0), e: (k == PC - 1)});
        end
        send_frame();
        chk("ov_drained", 32'(frames_stored), 0);

        // asynchronous reset mid-receive
        buffer_out_x = 2'd3;
        buffer_out_y = 1'b1;
        @(negedge clock);
        chk("ap_last_b", 32'(buffer_out_data), 88);
        recv_frame(91, 3);
        @(negedge clock);
        chk("ap_last_c", 32'(buffer_out_data), 98);
        in_request_external = 1'b1;
        @(negedge clock);
        chk("ar_armed", 32'(i_ready), 1);
        in_request_external = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_pix(101 + k, k == 0, 1'b0);
            @(negedge clock);
        end
        #2 reset = 1'b0;
        #1;
        chk("ar_receiving", 32'(in_receiving), 0);
        chk("ar_ready", 32'(i_ready), 0);
        chk("ar_request", 32'(i_request), 0);
        chk("ar_stored", 32'(frames_stored), 0);
        chk("ar_dropped", 32'(frame_dropped), 0);
        chk("ar_out_valid", 32'(o_valid), 0);
        chk("ar_access", 32'(buffer_out_data), 0);
        idle_in();
        q.delete();
        @(negedge clock);
        reset = 1'b1;
        out_request_external = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("ar_nothing_sent", 32'(o_valid), 0);
        end
        out_request_external = 1'b0;
        recv_frame(111, 3);
        send_frame();
        chk("ar_recovered", 32'(frames_stored), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
